// File: rtl/rv_pkg.sv
// Shared fetch-side types and constants.
package rv_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h00000013;

  // One fetch response as carried through the latency pipe and response buffer.
  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] inst;
    logic            fault;
  } fetch_rsp_t;

  localparam int unsigned FETCH_RSP_W = $bits(fetch_rsp_t);

  // Misaligned, or a byte address beyond the 2**addr_w word array.
  function automatic logic fetch_fault(input logic [XLEN-1:0] addr, input int unsigned addr_w);
    logic [XLEN-1:0] hi;
    hi = addr >> (addr_w + 2);
    return (addr[1:0] != 2'b00) || (hi != '0);
  endfunction

endpackage

// File: rtl/resp_fifo.sv
// Synchronous FIFO with a clear input; push on full is allowed when popping the same cycle.
module resp_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             full, do_push, do_pop;

  assign full    = (cnt_q == CntW'(Depth));
  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && (!full || do_pop);

  // Pointer/count next state; clear wins over any push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      cnt_d = cnt_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  // Pointer/count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage; a write into a slot being cleared is harmless since the count drops to zero.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/imem_responder.sv
// Instruction-fetch responder: word RAM, fixed-latency read pipe, credit-limited response FIFO.
module imem_responder
  import rv_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned LATENCY   = 2,
  parameter int unsigned BUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [XLEN-1:0]   req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_inst,
  output logic [XLEN-1:0]   rsp_addr,
  output logic              rsp_fault,
  input  logic              flush,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [XLEN-1:0]   ld_data
);

  localparam int unsigned CntW = $clog2(BUF_DEPTH) + 1;

  logic [XLEN-1:0]  mem_q [2**ADDR_W];
  logic [LATENCY-1:0] pipe_vld_q, pipe_vld_d;
  fetch_rsp_t       pipe_q [LATENCY];
  fetch_rsp_t       stage0_d;
  fetch_rsp_t       head;
  logic [CntW-1:0]  inflight, count;
  logic [CntW:0]    credits_used;
  logic             accept, req_fault, fifo_empty;
  logic [ADDR_W-1:0] word_idx;

  // Number of requests still travelling through the latency pipe.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++) begin
      inflight = inflight + CntW'(pipe_vld_q[i]);
    end
  end

  // Every accepted request holds a credit until its entry leaves the buffer.
  assign credits_used = {1'b0, inflight} + {1'b0, count};
  assign req_ready    = !flush && (credits_used < (CntW + 1)'(BUF_DEPTH));
  assign accept       = req_valid && req_ready;

  assign req_fault = fetch_fault(req_addr, ADDR_W);
  assign word_idx  = req_addr[ADDR_W+1:2];

  // Stage-0 payload; memory is sampled before this edge's load-port write.
  always_comb begin
    stage0_d.addr  = req_addr;
    stage0_d.inst  = req_fault ? NOP_INST : mem_q[word_idx];
    stage0_d.fault = req_fault;
  end

  // Pipe valid shift; flush drops everything in flight.
  always_comb begin
    pipe_vld_d = '0;
    if (!flush) begin
      pipe_vld_d[0] = accept;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_vld_d[i] = pipe_vld_q[i-1];
      end
    end
  end

  // Pipe valid register.
  always_ff @(posedge clk) begin
    if (rst) pipe_vld_q <= '0;
    else     pipe_vld_q <= pipe_vld_d;
  end

  // Pipe payload shifts unconditionally; only the valid bits matter.
  always_ff @(posedge clk) begin
    pipe_q[0] <= stage0_d;
    for (int i = 1; i < LATENCY; i++) begin
      pipe_q[i] <= pipe_q[i-1];
    end
  end

  // Load port; deliberately not reset.
  always_ff @(posedge clk) begin
    if (ld_we) mem_q[ld_addr] <= ld_data;
  end

  resp_fifo #(
    .Width (FETCH_RSP_W),
    .Depth (BUF_DEPTH)
  ) u_resp_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (flush),
    .push_i  (pipe_vld_q[LATENCY-1]),
    .wdata_i (pipe_q[LATENCY-1]),
    .pop_i   (rsp_valid && rsp_ready),
    .rdata_o (head),
    .empty_o (fifo_empty),
    .count_o (count)
  );

  // Payload is forced to zero while the buffer is empty so reset/flush show clean outputs.
  assign rsp_valid = !fifo_empty;
  assign rsp_inst  = rsp_valid ? head.inst  : '0;
  assign rsp_addr  = rsp_valid ? head.addr  : '0;
  assign rsp_fault = rsp_valid ? head.fault : 1'b0;

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboarded bench for imem_responder (ADDR_W=10, LATENCY=2, BUF_DEPTH=4).
module tb_imem_responder;

  localparam int unsigned ADDR_W    = 10;
  localparam int unsigned LATENCY   = 2;
  localparam int unsigned BUF_DEPTH = 4;
  localparam logic [31:0] NOP       = 32'h00000013;

  logic              clk = 1'b0;
  logic              rst, req_valid, req_ready, rsp_valid, rsp_ready, rsp_fault, flush, ld_we;
  logic [31:0]       req_addr, rsp_inst, rsp_addr, ld_data;
  logic [ADDR_W-1:0] ld_addr;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] inst;
    logic        fault;
    int          acc_cyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          lat_q[$];
  logic [31:0] model_mem [1024];
  logic [31:0] prog [4];
  logic [31:0] last_inst, last_addr, mon_a;
  logic        last_fault, mon_f;
  int          total = 0, bad = 0, cyc = 0, acc_cnt = 0, rsp_cnt = 0;

  imem_responder #(
    .ADDR_W    (ADDR_W),
    .LATENCY   (LATENCY),
    .BUF_DEPTH (BUF_DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_inst  (rsp_inst),
    .rsp_addr  (rsp_addr),
    .rsp_fault (rsp_fault),
    .flush     (flush),
    .ld_we     (ld_we),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pop/compare delivered responses, push expectations on accept, track loads.
  always @(negedge clk) begin
    if (!rst) begin
      if (rsp_valid && rsp_ready) begin
        rsp_cnt++;
        last_inst  = rsp_inst;
        last_addr  = rsp_addr;
        last_fault = rsp_fault;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected: got addr=%h inst=%h, required no response",
                   rsp_addr, rsp_inst);
        end else begin
          mon_e = exp_q.pop_front();
          lat_q.push_back(cyc - mon_e.acc_cyc);
          total++;
          if (rsp_inst !== mon_e.inst) begin
            bad++;
            $display("FAIL sb_inst: got %h, required %h (addr %h)", rsp_inst, mon_e.inst,
                     mon_e.addr);
          end
          total++;
          if (rsp_addr !== mon_e.addr) begin
            bad++;
            $display("FAIL sb_addr: got %h, required %h", rsp_addr, mon_e.addr);
          end
          total++;
          if (rsp_fault !== mon_e.fault) begin
            bad++;
            $display("FAIL sb_fault: got %b, required %b (addr %h)", rsp_fault, mon_e.fault,
                     mon_e.addr);
          end
        end
      end
      if (req_valid && req_ready) begin
        acc_cnt++;
        mon_a = req_addr;
        mon_f = (mon_a[1:0] != 2'b00) || (mon_a[31:12] != 20'h0);
        mon_e.addr    = mon_a;
        mon_e.fault   = mon_f;
        mon_e.inst    = mon_f ? NOP : model_mem[mon_a[11:2]];
        mon_e.acc_cyc = cyc;
        exp_q.push_back(mon_e);
      end
      if (flush) exp_q.delete();
    end else begin
      exp_q.delete();
    end
    if (ld_we) model_mem[ld_addr] = ld_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    ld_we   = 1'b1;
    ld_addr = a;
    ld_data = d;
    tick();
    ld_we   = 1'b0;
  endtask

  // Bounded wait for the delivered-response count to reach target; resyncs to posedge+1.
  task automatic wait_rsp(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (rsp_cnt >= target) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0; flush = 1'b0;
    ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b, required 0", rsp_valid); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready: got %b, required 1", req_ready); end
    total++; if (rsp_inst !== 32'h0) begin bad++; $display("FAIL reset_rsp_inst: got %h, required 0", rsp_inst); end
    total++; if (rsp_addr !== 32'h0) begin bad++; $display("FAIL reset_rsp_addr: got %h, required 0", rsp_addr); end
    total++; if (rsp_fault !== 1'b0) begin bad++; $display("FAIL reset_rsp_fault: got %b, required 0", rsp_fault); end
    tick();
  endtask

  task automatic test_in_order();
    int r0;
    bit ok;
    prog[0] = 32'h00500093; prog[1] = 32'h00A00113; prog[2] = 32'h002081B3; prog[3] = 32'h0000006F;
    for (int i = 0; i < 4; i++) load_word(ADDR_W'(i), prog[i]);
    rsp_ready = 1'b1;
    r0 = rsp_cnt;
    lat_q.delete();
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1;
      req_addr  = 32'(i * 4);
      tick();
    end
    req_valid = 1'b0;
    wait_rsp(r0 + 4, ok);
    total++; if (!ok) begin bad++; $display("FAIL in_order_count: got %0d responses, required 4", rsp_cnt - r0); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= lat_q.size()) begin
        bad++; $display("FAIL in_order_latency[%0d]: got no response, required latency %0d", i, LATENCY + 1);
      end else if (lat_q[i] != LATENCY + 1) begin
        bad++; $display("FAIL in_order_latency[%0d]: got %0d, required %0d", i, lat_q[i], LATENCY + 1);
      end
    end
  endtask

  task automatic test_backpressure();
    int a0, r0;
    bit ok, seen, unstable;
    logic [64:0] hold;
    rsp_ready = 1'b0;
    a0 = acc_cnt; r0 = rsp_cnt; seen = 1'b0; unstable = 1'b0; hold = '0;
    for (int i = 0; i < 10; i++) begin
      req_valid = 1'b1;
      req_addr  = 32'((i % 4) * 4);
      @(negedge clk);
      if (rsp_valid) begin
        if (!seen) begin
          hold = {rsp_inst, rsp_addr, rsp_fault};
          seen = 1'b1;
        end else if ({rsp_inst, rsp_addr, rsp_fault} !== hold) begin
          unstable = 1'b1;
        end
      end
      tick();
    end
    req_valid = 1'b0;
    @(negedge clk);
    #1;
    total++; if (acc_cnt - a0 != BUF_DEPTH) begin bad++; $display("FAIL bp_accepted: got %0d, required %0d", acc_cnt - a0, BUF_DEPTH); end
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_req_ready_full: got %b, required 0", req_ready); end
    total++; if (unstable || !seen) begin bad++; $display("FAIL bp_stable: got unstable=%b seen=%b, required 0/1", unstable, seen); end
    total++; if (rsp_cnt != r0) begin bad++; $display("FAIL bp_no_pop: got %0d, required 0", rsp_cnt - r0); end
    tick();
    rsp_ready = 1'b1;
    wait_rsp(r0 + 4, ok);
    repeat (3) tick();
    @(negedge clk);
    #1;
    total++; if (!ok || rsp_cnt - r0 != 4) begin bad++; $display("FAIL bp_drained: got %0d, required 4", rsp_cnt - r0); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL bp_req_ready_after: got %b, required 1", req_ready); end
    tick();
  endtask

  task automatic test_fault();
    int r0;
    bit ok;
    rsp_ready = 1'b1;
    r0 = rsp_cnt;
    req_valid = 1'b1; req_addr = 32'h00000006; tick();
    req_addr = 32'h00001000; tick();
    req_valid = 1'b0;
    wait_rsp(r0 + 2, ok);
    total++; if (!ok) begin bad++; $display("FAIL fault_count: got %0d, required 2", rsp_cnt - r0); end
    total++; if (last_inst !== NOP || last_fault !== 1'b1 || last_addr !== 32'h00001000) begin
      bad++; $display("FAIL fault_range: got inst=%h fault=%b addr=%h, required %h/1/00001000",
                      last_inst, last_fault, last_addr, NOP);
    end
  endtask

  task automatic test_flush();
    int r0, a0;
    bit ok;
    rsp_ready = 1'b0;
    r0 = rsp_cnt;
    req_valid = 1'b1; req_addr = 32'h0; tick();
    req_addr = 32'h4; tick();
    req_addr = 32'h8; tick();
    a0 = acc_cnt;
    flush = 1'b1; req_addr = 32'hC;
    @(negedge clk);
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL flush_req_ready: got %b, required 0", req_ready); end
    tick();
    flush = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL flush_rsp_valid: got %b, required 0", rsp_valid); end
    tick();
    rsp_ready = 1'b1;
    repeat (8) tick();
    total++; if (rsp_cnt != r0 || acc_cnt != a0) begin
      bad++; $display("FAIL flush_dropped: got rsp=%0d acc=%0d, required 0/0", rsp_cnt - r0, acc_cnt - a0);
    end
    r0 = rsp_cnt;
    req_valid = 1'b1; req_addr = 32'h8; tick();
    req_valid = 1'b0;
    wait_rsp(r0 + 1, ok);
    total++; if (!ok || last_inst !== 32'h002081B3) begin
      bad++; $display("FAIL flush_after: got inst=%h ok=%b, required 002081b3", last_inst, ok);
    end
  endtask

  task automatic test_load_collision();
    int r0;
    bit ok;
    rsp_ready = 1'b1;
    r0 = rsp_cnt;
    ld_we = 1'b1; ld_addr = ADDR_W'(2); ld_data = 32'hDEADBEEF;
    req_valid = 1'b1; req_addr = 32'h8;
    tick();
    ld_we = 1'b0; req_valid = 1'b0;
    wait_rsp(r0 + 1, ok);
    total++; if (!ok || last_inst !== 32'h002081B3) begin
      bad++; $display("FAIL rbw_old: got inst=%h ok=%b, required 002081b3", last_inst, ok);
    end
    r0 = rsp_cnt;
    req_valid = 1'b1; req_addr = 32'h8; tick();
    req_valid = 1'b0;
    wait_rsp(r0 + 1, ok);
    total++; if (!ok || last_inst !== 32'hDEADBEEF) begin
      bad++; $display("FAIL rbw_new: got inst=%h ok=%b, required deadbeef", last_inst, ok);
    end
  endtask

  task automatic test_reset_mid();
    int r0;
    rsp_ready = 1'b0;
    r0 = rsp_cnt;
    req_valid = 1'b1; req_addr = 32'h0; tick();
    req_addr = 32'h4; tick();
    req_valid = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL rmid_pre_valid: got %b, required 1", rsp_valid); end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rmid_rsp_valid: got %b, required 0", rsp_valid); end
    total++; if (rsp_inst !== 32'h0 || rsp_addr !== 32'h0 || rsp_fault !== 1'b0) begin
      bad++; $display("FAIL rmid_outputs: got inst=%h addr=%h fault=%b, required 0/0/0",
                      rsp_inst, rsp_addr, rsp_fault);
    end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rmid_req_ready: got %b, required 1", req_ready); end
    tick();
    rsp_ready = 1'b1;
    repeat (8) tick();
    total++; if (rsp_cnt != r0) begin bad++; $display("FAIL rmid_stale: got %0d responses, required 0", rsp_cnt - r0); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_in_order();
    test_backpressure();
    test_fault();
    test_flush();
    test_load_collision();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
